hwpe_accel: RTL and testbench

- EAI-attached (NICE-style) convolution coprocessor for the RV MCU.
- A DMA port fills on-chip feature-map and kernel scratchpads.
- Custom instructions configure the block, run 8-lane signed int8 dot-products into 32-bit accumulators, and read the results back through the EAI response channel.
- The EAI memory (ICB) channel is present but unused and tied off.

---
 rtl/hwpe_accel.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_hwpe_accel.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hwpe_accel.sv
// hwpe_accel: EAI-attached 8-lane int8 dot-product coprocessor with DMA-filled scratchpads.
// Define HWPE_ACC_SAT_EN to make accumulator updates saturate instead of wrapping.

module hwpe_accel #(
    parameter int ADDR_WIDTH       = 16,
    parameter int FMEM_ADDR2_START = 'h2000,
    parameter int KMEM_ADDR_START  = 'h4000,
    parameter int BANK_DEPTH       = 1024,
    parameter int ACC_NUM          = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  dma_wen,
    input  logic [ADDR_WIDTH-1:0] dma_wa,
    input  logic [63:0]           dma_wd,
    input  logic                  eai_req_valid,
    output logic                  eai_req_ready,
    input  logic [31:0]           eai_req_instr,
    input  logic [31:0]           eai_req_rs1,
    input  logic [31:0]           eai_req_rs2,
    input  logic [1:0]            eai_req_itag,
    output logic                  eai_rsp_valid,
    input  logic                  eai_rsp_ready,
    output logic [31:0]           eai_rsp_wdat,
    output logic [1:0]            eai_rsp_itag,
    output logic                  eai_rsp_err,
    output logic                  eai_icb_cmd_valid,
    input  logic                  eai_icb_cmd_ready,
    output logic [31:0]           eai_icb_cmd_addr,
    output logic                  eai_icb_cmd_read,
    output logic [31:0]           eai_icb_cmd_wdata,
    output logic [3:0]            eai_icb_cmd_wmask,
    input  logic                  eai_icb_rsp_valid,
    output logic                  eai_icb_rsp_ready,
    input  logic [31:0]           eai_icb_rsp_rdata,
    input  logic                  eai_icb_rsp_err,
    output logic                  eai_mem_holdup
);

    localparam int IDX_W = $clog2(BANK_DEPTH);
    localparam int ACC_W = (ACC_NUM > 1) ? $clog2(ACC_NUM) : 1;

    localparam logic [ADDR_WIDTH-1:0] F2_BASE   = ADDR_WIDTH'(FMEM_ADDR2_START);
    localparam logic [ADDR_WIDTH-1:0] K_BASE    = ADDR_WIDTH'(KMEM_ADDR_START);
    localparam logic [ADDR_WIDTH-1:0] DEPTH_A   = ADDR_WIDTH'(BANK_DEPTH);
    localparam logic [31:0]           F2_BASE32 = 32'(FMEM_ADDR2_START);
    localparam logic [31:0]           DEPTH32   = 32'(BANK_DEPTH);
    localparam logic [31:0]           ACCN32    = 32'(ACC_NUM);
    localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(BANK_DEPTH - 1);

    localparam logic [6:0] OP_CFG = 7'h01;
    localparam logic [6:0] OP_CLR = 7'h02;
    localparam logic [6:0] OP_MAC = 7'h03;
    localparam logic [6:0] OP_RD  = 7'h04;

    // IDLE: accepting | EXEC: op in flight, MAC issues/drains | RESP: holding response
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    state_t state, state_nx;

    logic [6:0]             op_q;
    logic [15:0]            rs1_q;
    logic [1:0]             itag_q;
    logic                   fsel;
    logic [ACC_W-1:0]       acc_sel;
    logic [15:0]            len;
    logic [15:0]            remaining;
    logic                   rd_vld;
    logic [IDX_W-1:0]       f_ptr;
    logic [IDX_W-1:0]       k_ptr;
    logic [31:0]            acc [ACC_NUM];

    logic                   accept;
    logic                   issue;
    logic                   finish;

    // ---------------- DMA write decode ----------------
    logic [1:0]             dma_sel;
    logic [ADDR_WIDTH-1:0]  dma_off;
    logic [ADDR_WIDTH-1:0]  dma_word;
    logic                   dma_hit;
    logic [IDX_W-1:0]       dma_idx;

    always_comb begin
        dma_sel = 2'd0;
        dma_off = dma_wa;
        if (dma_wa < F2_BASE) begin
            dma_sel = 2'd0;
            dma_off = dma_wa;
        end else if (dma_wa < K_BASE) begin
            dma_sel = 2'd1;
            dma_off = dma_wa - F2_BASE;
        end else begin
            dma_sel = 2'd2;
            dma_off = dma_wa - K_BASE;
        end
        dma_word = dma_off >> 3;
        dma_hit  = dma_wen && (dma_word < DEPTH_A);
        dma_idx  = dma_word[IDX_W-1:0];
    end

    // ---------------- Scratchpads (read-first, 1-cycle latency) ----------------
    logic [63:0] fmem0 [BANK_DEPTH];
    logic [63:0] fmem1 [BANK_DEPTH];
    logic [63:0] kmem  [BANK_DEPTH];
    logic [63:0] f0_q;
    logic [63:0] f1_q;
    logic [63:0] k_q;

    always_ff @(posedge clk) begin
        if (dma_hit && (dma_sel == 2'd0)) begin
            fmem0[dma_idx] <= dma_wd;
        end
        f0_q <= fmem0[f_ptr];
    end

    always_ff @(posedge clk) begin
        if (dma_hit && (dma_sel == 2'd1)) begin
            fmem1[dma_idx] <= dma_wd;
        end
        f1_q <= fmem1[f_ptr];
    end

    always_ff @(posedge clk) begin
        if (dma_hit && (dma_sel == 2'd2)) begin
            kmem[dma_idx] <= dma_wd;
        end
        k_q <= kmem[k_ptr];
    end

    // ---------------- Request decode ----------------
    logic [6:0]       req_op;
    logic             req_fsel;
    logic [31:0]      req_fbase;
    logic [IDX_W-1:0] req_fstart;
    logic [IDX_W-1:0] req_kstart;
    logic [ACC_W-1:0] req_acc;
    logic [ACC_W-1:0] rd_sel;

    assign req_op     = eai_req_instr[31:25];
    assign req_fsel   = (eai_req_rs1 >= F2_BASE32);
    assign req_fbase  = req_fsel ? F2_BASE32 : 32'd0;
    assign req_fstart = IDX_W'(((eai_req_rs1 - req_fbase) >> 3) % DEPTH32);
    assign req_kstart = IDX_W'((32'(eai_req_rs2[15:0]) >> 3) % DEPTH32);
    assign req_acc    = ACC_W'(32'(eai_req_rs2[31:30]) % ACCN32);
    assign rd_sel     = ACC_W'(32'(rs1_q[1:0]) % ACCN32);

    // ---------------- Lane products and accumulate ----------------
    logic [63:0]        f_data;
    logic signed [15:0] fa [8];
    logic signed [15:0] kb [8];
    logic signed [15:0] prod [8];
    logic signed [31:0] lane_sum;
    logic [32:0]        acc_sum;
    logic [31:0]        acc_upd;

    assign f_data = fsel ? f1_q : f0_q;

    always_comb begin
        lane_sum = '0;
        for (int i = 0; i < 8; i++) begin
            fa[i]    = {{8{f_data[8*i+7]}}, f_data[8*i +: 8]};
            kb[i]    = {{8{k_q[8*i+7]}}, k_q[8*i +: 8]};
            prod[i]  = fa[i] * kb[i];
            lane_sum = lane_sum + {{16{prod[i][15]}}, prod[i]};
        end
    end

    always_comb begin
        acc_sum = {acc[acc_sel][31], acc[acc_sel]} + {lane_sum[31], lane_sum};
`ifdef HWPE_ACC_SAT_EN
        if (acc_sum[32] != acc_sum[31]) begin
            acc_upd = acc_sum[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end else begin
            acc_upd = acc_sum[31:0];
        end
`else
        acc_upd = acc_sum[31:0];
`endif
    end

    // ---------------- Control FSM ----------------
    assign accept = eai_req_valid && eai_req_ready;
    assign issue  = (state == EXEC) && (remaining != 16'd0);
    // finish waits for the last read to drain so the accumulator is final
    assign finish = (state == EXEC) && (remaining == 16'd0) && !rd_vld;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (eai_req_valid) state_nx = EXEC;
            EXEC: if (finish) state_nx = RESP;
            RESP: if (eai_rsp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign eai_req_ready = (state == IDLE);
    assign eai_rsp_valid = (state == RESP);

    // ---------------- Datapath registers ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q         <= '0;
            rs1_q        <= '0;
            itag_q       <= '0;
            fsel         <= 1'b0;
            acc_sel      <= '0;
            len          <= 16'd1;
            remaining    <= '0;
            rd_vld       <= 1'b0;
            f_ptr        <= '0;
            k_ptr        <= '0;
            eai_rsp_wdat <= '0;
            eai_rsp_itag <= '0;
            eai_rsp_err  <= 1'b0;
            for (int i = 0; i < ACC_NUM; i++) begin
                acc[i] <= '0;
            end
        end else begin
            rd_vld <= issue;
            if (accept) begin
                op_q      <= req_op;
                rs1_q     <= eai_req_rs1[15:0];
                itag_q    <= eai_req_itag;
                fsel      <= req_fsel;
                acc_sel   <= req_acc;
                f_ptr     <= req_fstart;
                k_ptr     <= req_kstart;
                remaining <= (req_op == OP_MAC) ? len : 16'd0;
            end
            if (issue) begin
                remaining <= remaining - 16'd1;
                f_ptr     <= (f_ptr == IDX_LAST) ? '0 : f_ptr + IDX_W'(1);
                k_ptr     <= (k_ptr == IDX_LAST) ? '0 : k_ptr + IDX_W'(1);
            end
            if (rd_vld) begin
                acc[acc_sel] <= acc_upd;
            end
            if (finish) begin
                eai_rsp_itag <= itag_q;
                eai_rsp_err  <= 1'b0;
                eai_rsp_wdat <= '0;
                case (op_q)
                    OP_CFG: len <= rs1_q;
                    OP_CLR: begin
                        for (int i = 0; i < ACC_NUM; i++) begin
                            acc[i] <= '0;
                        end
                    end
                    OP_MAC: ;
                    OP_RD:  eai_rsp_wdat <= acc[rd_sel];
                    default: eai_rsp_err <= 1'b1;
                endcase
            end
        end
    end

    // ---------------- Unused ICB channel ----------------
    assign eai_icb_cmd_valid = 1'b0;
    assign eai_icb_cmd_addr  = '0;
    assign eai_icb_cmd_read  = 1'b0;
    assign eai_icb_cmd_wdata = '0;
    assign eai_icb_cmd_wmask = '0;
    assign eai_icb_rsp_ready = 1'b1;
    assign eai_mem_holdup    = 1'b0;

    logic unused_ok;
    assign unused_ok = ^{eai_icb_cmd_ready, eai_icb_rsp_valid, eai_icb_rsp_rdata,
                         eai_icb_rsp_err, eai_req_instr[24:0], eai_req_rs2[29:16],
                         acc_sum[32]};

endmodule

// File: tb/tb_hwpe_accel.sv
// Directed bench for hwpe_accel: expected responses queued at issue, compared on the response channel.

module tb_hwpe_accel;

    localparam logic [6:0] OP_CFG = 7'h01;
    localparam logic [6:0] OP_CLR = 7'h02;
    localparam logic [6:0] OP_MAC = 7'h03;
    localparam logic [6:0] OP_RD  = 7'h04;

    logic        clk = 1'b0;
    logic        rst;
    logic        dma_wen;
    logic [15:0] dma_wa;
    logic [63:0] dma_wd;
    logic        eai_req_valid;
    logic        eai_req_ready;
    logic [31:0] eai_req_instr;
    logic [31:0] eai_req_rs1;
    logic [31:0] eai_req_rs2;
    logic [1:0]  eai_req_itag;
    logic        eai_rsp_valid;
    logic        eai_rsp_ready;
    logic [31:0] eai_rsp_wdat;
    logic [1:0]  eai_rsp_itag;
    logic        eai_rsp_err;
    logic        eai_icb_cmd_valid;
    logic        eai_icb_cmd_ready;
    logic [31:0] eai_icb_cmd_addr;
    logic        eai_icb_cmd_read;
    logic [31:0] eai_icb_cmd_wdata;
    logic [3:0]  eai_icb_cmd_wmask;
    logic        eai_icb_rsp_valid;
    logic        eai_icb_rsp_ready;
    logic [31:0] eai_icb_rsp_rdata;
    logic        eai_icb_rsp_err;
    logic        eai_mem_holdup;

    always #5 clk = ~clk;

    hwpe_accel #(
        .ADDR_WIDTH       (16),
        .FMEM_ADDR2_START ('h2000),
        .KMEM_ADDR_START  ('h4000),
        .BANK_DEPTH       (1024),
        .ACC_NUM          (4)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .dma_wen           (dma_wen),
        .dma_wa            (dma_wa),
        .dma_wd            (dma_wd),
        .eai_req_valid     (eai_req_valid),
        .eai_req_ready     (eai_req_ready),
        .eai_req_instr     (eai_req_instr),
        .eai_req_rs1       (eai_req_rs1),
        .eai_req_rs2       (eai_req_rs2),
        .eai_req_itag      (eai_req_itag),
        .eai_rsp_valid     (eai_rsp_valid),
        .eai_rsp_ready     (eai_rsp_ready),
        .eai_rsp_wdat      (eai_rsp_wdat),
        .eai_rsp_itag      (eai_rsp_itag),
        .eai_rsp_err       (eai_rsp_err),
        .eai_icb_cmd_valid (eai_icb_cmd_valid),
        .eai_icb_cmd_ready (eai_icb_cmd_ready),
        .eai_icb_cmd_addr  (eai_icb_cmd_addr),
        .eai_icb_cmd_read  (eai_icb_cmd_read),
        .eai_icb_cmd_wdata (eai_icb_cmd_wdata),
        .eai_icb_cmd_wmask (eai_icb_cmd_wmask),
        .eai_icb_rsp_valid (eai_icb_rsp_valid),
        .eai_icb_rsp_ready (eai_icb_rsp_ready),
        .eai_icb_rsp_rdata (eai_icb_rsp_rdata),
        .eai_icb_rsp_err   (eai_icb_rsp_err),
        .eai_mem_holdup    (eai_mem_holdup)
    );

    typedef struct packed {
        logic [31:0] data;
        logic        err;
        logic [1:0]  tag;
    } exp_t;

    exp_t        sbq[$];
    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] m_acc [4];

    localparam logic [63:0] W_ONES = 64'h0101_0101_0101_0101;
    localparam logic [63:0] W_NEG1 = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] W_TWO  = 64'h0202_0202_0202_0202;
    localparam logic [63:0] F1     = 64'h807F_03FD_10F0_05FE;
    localparam logic [63:0] K1     = 64'h0203_FE7F_8104_0506;
    localparam logic [63:0] FW     = 64'h1122_3344_5566_7788;
    localparam logic [63:0] KW     = 64'hF1E2_D3C4_B5A6_9788;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] dot8(input logic [63:0] f, input logic [63:0] k);
        int s;
        s = 0;
        for (int i = 0; i < 8; i++) begin
            s += int'($signed(f[8*i +: 8])) * int'($signed(k[8*i +: 8]));
        end
        return 32'(s);
    endfunction

    task automatic dma_write(input logic [15:0] a, input logic [63:0] d);
        dma_wen = 1'b1;
        dma_wa  = a;
        dma_wd  = d;
        @(posedge clk); #1;
        dma_wen = 1'b0;
    endtask

    // Issue one instruction, queue its expected response, return wait and latency counts.
    task automatic send(input logic [6:0] op, input logic [31:0] rs1, input logic [31:0] rs2,
                        input logic [1:0] tag, input logic [31:0] exp_data, input logic exp_err,
                        output int waits, output int lat);
        exp_t e;
        e.data = exp_data;
        e.err  = exp_err;
        e.tag  = tag;
        sbq.push_back(e);
        eai_req_instr = {op, 10'h000, tag[0], 14'h0000};
        eai_req_rs1   = rs1;
        eai_req_rs2   = rs2;
        eai_req_itag  = tag;
        eai_req_valid = 1'b1;
        waits = 0;
        while (!eai_req_ready && waits < 20) begin
            @(posedge clk); #1;
            waits++;
        end
        check("req_ready_at_accept", 32'(eai_req_ready), 32'd1);
        @(posedge clk); #1;
        eai_req_valid = 1'b0;
        @(posedge clk); #1;
        lat = 1;
        while (!eai_rsp_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic take_rsp(input string tag);
        exp_t e;
        check({tag, "_valid"}, 32'(eai_rsp_valid), 32'd1);
        check({tag, "_sb_nonempty"}, 32'(sbq.size() != 0), 32'd1);
        if (sbq.size() != 0) begin
            e = sbq.pop_front();
            check({tag, "_wdat"}, eai_rsp_wdat, e.data);
            check({tag, "_err"}, 32'(eai_rsp_err), 32'(e.err));
            check({tag, "_itag"}, 32'(eai_rsp_itag), 32'(e.tag));
        end
        eai_rsp_ready = 1'b1;
        @(posedge clk); #1;
        eai_rsp_ready = 1'b0;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 4; i++) m_acc[i] = 32'd0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w;
        int lat;
        rst = 1'b1;
        dma_wen = 1'b0; dma_wa = '0; dma_wd = '0;
        eai_req_valid = 1'b0; eai_req_instr = '0; eai_req_rs1 = '0; eai_req_rs2 = '0;
        eai_req_itag = '0; eai_rsp_ready = 1'b0;
        eai_icb_cmd_ready = 1'b0; eai_icb_rsp_valid = 1'b0; eai_icb_rsp_rdata = '0;
        eai_icb_rsp_err = 1'b0;
        clear_model();

        // reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready", 32'(eai_req_ready), 32'd1);
        check("rst_rsp_valid", 32'(eai_rsp_valid), 32'd0);
        check("rst_rsp_wdat", eai_rsp_wdat, 32'd0);
        check("rst_rsp_err", 32'(eai_rsp_err), 32'd0);
        check("rst_rsp_itag", 32'(eai_rsp_itag), 32'd0);
        check("icb_cmd_valid", 32'(eai_icb_cmd_valid), 32'd0);
        check("icb_cmd_addr", eai_icb_cmd_addr, 32'd0);
        check("icb_cmd_read", 32'(eai_icb_cmd_read), 32'd0);
        check("icb_cmd_wdata", eai_icb_cmd_wdata, 32'd0);
        check("icb_cmd_wmask", 32'(eai_icb_cmd_wmask), 32'd0);
        check("icb_rsp_ready", 32'(eai_icb_rsp_ready), 32'd1);
        check("mem_holdup", 32'(eai_mem_holdup), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // basic dot product of all-ones words
        dma_write(16'h0000, W_ONES);
        dma_write(16'h4000, W_ONES);
        send(OP_CFG, 32'd1, 32'd0, 2'd0, 32'd0, 1'b0, w, lat);
        check("cfg_lat", 32'(lat), 32'd1);
        take_rsp("cfg1");
        send(OP_CLR, 32'd0, 32'd0, 2'd1, 32'd0, 1'b0, w, lat);
        check("clr_lat", 32'(lat), 32'd1);
        take_rsp("clr1");
        clear_model();
        send(OP_MAC, 32'd0, 32'd0, 2'd1, 32'd0, 1'b0, w, lat);
        check("mac_len1_lat", 32'(lat), 32'd3);
        take_rsp("mac1");
        m_acc[0] = m_acc[0] + dot8(W_ONES, W_ONES);
        send(OP_RD, 32'd0, 32'd0, 2'd3, 32'd8, 1'b0, w, lat);
        check("rd_lat", 32'(lat), 32'd1);
        take_rsp("rd_acc0_ones");

        // negative fmap times 2, LEN=4, into acc 2
        for (int i = 0; i < 4; i++) begin
            dma_write(16'h0100 + 16'(8 * i), W_NEG1);
            dma_write(16'h4100 + 16'(8 * i), W_TWO);
        end
        send(OP_CFG, 32'd4, 32'd0, 2'd0, 32'd0, 1'b0, w, lat);
        take_rsp("cfg4");
        send(OP_MAC, 32'h0000_0100, 32'h8000_0100, 2'd2, 32'd0, 1'b0, w, lat);
        check("mac_len4_lat", 32'(lat), 32'd6);
        take_rsp("mac4");
        for (int i = 0; i < 4; i++) m_acc[2] = m_acc[2] + dot8(W_NEG1, W_TWO);
        send(OP_RD, 32'd2, 32'd0, 2'd0, 32'hFFFF_FFC0, 1'b0, w, lat);
        take_rsp("rd_acc2_neg");

        // illegal op
        send(7'h7F, 32'd0, 32'd0, 2'd2, 32'd0, 1'b1, w, lat);
        check("illegal_lat", 32'(lat), 32'd1);
        take_rsp("illegal");
        send(OP_RD, 32'd0, 32'd0, 2'd1, m_acc[0], 1'b0, w, lat);
        take_rsp("rd_acc0_after_illegal");
        send(OP_RD, 32'd2, 32'd0, 2'd1, m_acc[2], 1'b0, w, lat);
        take_rsp("rd_acc2_after_illegal");

        // response back-pressure
        send(OP_RD, 32'd2, 32'd0, 2'd1, m_acc[2], 1'b0, w, lat);
        for (int i = 0; i < 5; i++) begin
            check("hold_rsp_valid", 32'(eai_rsp_valid), 32'd1);
            check("hold_rsp_wdat", eai_rsp_wdat, m_acc[2]);
            check("hold_rsp_itag", 32'(eai_rsp_itag), 32'd1);
            check("hold_req_ready", 32'(eai_req_ready), 32'd0);
            @(posedge clk); #1;
        end
        take_rsp("rd_held");
        check("req_ready_after_hs", 32'(eai_req_ready), 32'd1);
        send(OP_RD, 32'd0, 32'd0, 2'd3, m_acc[0], 1'b0, w, lat);
        check("accept_waits_after_hs", 32'(w), 32'd0);
        take_rsp("rd_after_hold");

        // bank 1 selection and accumulation
        dma_write(16'h2000, F1);
        dma_write(16'h4008, K1);
        send(OP_CFG, 32'd1, 32'd0, 2'd0, 32'd0, 1'b0, w, lat);
        take_rsp("cfg1b");
        send(OP_MAC, 32'h0000_2000, 32'h4000_0008, 2'd2, 32'd0, 1'b0, w, lat);
        check("mac_bank1_lat", 32'(lat), 32'd3);
        take_rsp("mac_bank1");
        m_acc[1] = m_acc[1] + dot8(F1, K1);
        send(OP_RD, 32'd1, 32'd0, 2'd2, m_acc[1], 1'b0, w, lat);
        take_rsp("rd_acc1_bank1");
        send(OP_MAC, 32'h0000_0000, 32'h4000_0008, 2'd0, 32'd0, 1'b0, w, lat);
        take_rsp("mac_bank0");
        m_acc[1] = m_acc[1] + dot8(W_ONES, K1);
        send(OP_RD, 32'd1, 32'd0, 2'd2, m_acc[1], 1'b0, w, lat);
        take_rsp("rd_acc1_accum");

        // out-of-range kernel write dropped, address wrap, LEN=0
        dma_write(16'h6000, W_NEG1);
        dma_write(16'h1FF8, FW);
        dma_write(16'h5FF8, KW);
        send(OP_CLR, 32'd0, 32'd0, 2'd1, 32'd0, 1'b0, w, lat);
        take_rsp("clr2");
        clear_model();
        send(OP_CFG, 32'd2, 32'd0, 2'd0, 32'd0, 1'b0, w, lat);
        take_rsp("cfg2");
        send(OP_MAC, 32'h0000_1FF8, 32'hC000_1FF8, 2'd3, 32'd0, 1'b0, w, lat);
        check("mac_wrap_lat", 32'(lat), 32'd4);
        take_rsp("mac_wrap");
        m_acc[3] = dot8(FW, KW) + dot8(W_ONES, W_ONES);
        send(OP_RD, 32'd3, 32'd0, 2'd3, m_acc[3], 1'b0, w, lat);
        take_rsp("rd_acc3_wrap");
        send(OP_RD, 32'd1, 32'd0, 2'd0, 32'd0, 1'b0, w, lat);
        take_rsp("rd_acc1_cleared");
        send(OP_CFG, 32'd0, 32'd0, 2'd0, 32'd0, 1'b0, w, lat);
        take_rsp("cfg0");
        send(OP_MAC, 32'd0, 32'hC000_0000, 2'd1, 32'd0, 1'b0, w, lat);
        check("mac_len0_lat", 32'(lat), 32'd1);
        take_rsp("mac_len0");
        send(OP_RD, 32'd3, 32'd0, 2'd3, m_acc[3], 1'b0, w, lat);
        take_rsp("rd_acc3_len0");

        // reset in the middle of a MAC
        send(OP_CFG, 32'd4, 32'd0, 2'd0, 32'd0, 1'b0, w, lat);
        take_rsp("cfg4b");
        send(OP_MAC, 32'h0000_0100, 32'h0000_0100, 2'd0, 32'd0, 1'b0, w, lat);
        take_rsp("mac_acc0");
        for (int i = 0; i < 4; i++) m_acc[0] = m_acc[0] + dot8(W_NEG1, W_TWO);
        send(OP_RD, 32'd0, 32'd0, 2'd0, m_acc[0], 1'b0, w, lat);
        take_rsp("rd_acc0_pre_abort");
        eai_req_instr = {OP_MAC, 25'h0};
        eai_req_rs1   = 32'h0000_0100;
        eai_req_rs2   = 32'h0000_0100;
        eai_req_itag  = 2'd0;
        eai_req_valid = 1'b1;
        @(posedge clk); #1;
        eai_req_valid = 1'b0;
        check("busy_req_ready", 32'(eai_req_ready), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #2;
        check("abort_req_ready", 32'(eai_req_ready), 32'd1);
        check("abort_rsp_valid", 32'(eai_rsp_valid), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        clear_model();
        @(posedge clk); #1;
        send(OP_RD, 32'd0, 32'd0, 2'd1, 32'd0, 1'b0, w, lat);
        take_rsp("rd_acc0_after_abort");
        send(OP_RD, 32'd2, 32'd0, 2'd1, 32'd0, 1'b0, w, lat);
        take_rsp("rd_acc2_after_abort");
        send(OP_MAC, 32'd0, 32'd0, 2'd2, 32'd0, 1'b0, w, lat);
        check("mac_len_reset_lat", 32'(lat), 32'd3);
        take_rsp("mac_after_abort");
        m_acc[0] = m_acc[0] + dot8(W_ONES, W_ONES);
        send(OP_RD, 32'd0, 32'd0, 2'd2, m_acc[0], 1'b0, w, lat);
        take_rsp("rd_acc0_final");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
